// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: decode control,
// FSM states, forwarding select codes and the EX/MEM shadow entry.
package hazard_ctrl_pkg;

    typedef logic [31:0] instruction_type;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } format_type;

    typedef struct packed {
        format_type fmt;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } control_type;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_DRAIN,
        HZ_TRAP,
        HZ_HALT
    } hazard_state_type;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_DECODE = 2'd1,
        CAUSE_REG    = 2'd2,
        CAUSE_BOTH   = 2'd3
    } trap_cause_type;

    localparam int unsigned FWD_REG    = 0;
    localparam int unsigned FWD_EX_MEM = 1;
    localparam int unsigned FWD_MEM_WB = 2;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } shadow_entry_type;

    function automatic logic uses_rs1(input format_type fmt);
        return fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    endfunction

    function automatic logic uses_rs2(input format_type fmt);
        return fmt inside {FMT_R, FMT_S, FMT_B};
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Matches one ID source register against the EX and MEM shadow entries:
// forwarding select (nearest producer wins) and load-use detection.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int FWD_SEL_W = 2
) (
    input  logic [4:0]           rs,
    input  logic                 rs_used,
    input  shadow_entry_type     ex_entry,
    input  shadow_entry_type     mem_entry,
    output logic [FWD_SEL_W-1:0] fwd_sel,
    output logic                 load_use
);

    logic ex_match;
    logic mem_match;
    logic ex_hit;
    logic mem_hit;

    assign ex_match  = ex_entry.valid && (ex_entry.rd != 5'd0) && (ex_entry.rd == rs);
    assign mem_match = mem_entry.valid && (mem_entry.rd != 5'd0) && (mem_entry.rd == rs);
    assign ex_hit    = ex_match && ex_entry.reg_write;
    assign mem_hit   = mem_match && mem_entry.reg_write;

    always_comb begin
        fwd_sel = FWD_SEL_W'(FWD_REG);
        if (ex_hit) begin
            fwd_sel = FWD_SEL_W'(FWD_EX_MEM);
        end else if (mem_hit) begin
            fwd_sel = FWD_SEL_W'(FWD_MEM_WB);
        end
    end

    assign load_use = rs_used && ex_match && ex_entry.mem_read;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, memory-wait freeze,
// branch flushes, operand forwarding and the illegal-instruction trap.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   HZ_RUN   | normal flow; watch ID for an illegal instruction
//   HZ_DRAIN | hold IF/ID, inject bubbles while the counter runs down
//   HZ_TRAP  | trap pulse, pipeline still held
//   HZ_HALT  | held with halted high until resume
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int FWD_SEL_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  instruction_type      id_instr,
    input  control_type          id_control,
    input  logic                 id_decode_failed,
    input  logic                 id_reg_illegal,
    input  logic                 ex_branch_taken,
    input  logic                 mem_ready,
    input  logic                 resume,
    output logic                 stall_if_id,
    output logic                 stall_all,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic [FWD_SEL_W-1:0] fwd_a_sel,
    output logic [FWD_SEL_W-1:0] fwd_b_sel,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic                 halted
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    hazard_state_type state;
    logic [2:0]       drain_cnt;
    trap_cause_type   cause_q;
    shadow_entry_type ex_entry;
    shadow_entry_type mem_entry;
    shadow_entry_type id_entry;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       load_use_a;
    logic       load_use_b;
    logic       load_use;
    logic       hold;
    logic       illegal;
    logic       unused_instr_bits;

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12], id_instr[6:0]};

    assign id_entry = '{
        valid:     id_valid,
        rd:        id_instr[11:7],
        reg_write: id_control.reg_write,
        mem_read:  id_control.mem_read,
        mem_write: id_control.mem_write
    };

    hazard_fwd_unit #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_a (
        .rs        (rs1),
        .rs_used   (id_valid && uses_rs1(id_control.fmt)),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .fwd_sel   (fwd_a_sel),
        .load_use  (load_use_a)
    );

    hazard_fwd_unit #(.FWD_SEL_W(FWD_SEL_W)) u_fwd_b (
        .rs        (rs2),
        .rs_used   (id_valid && uses_rs2(id_control.fmt)),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .fwd_sel   (fwd_b_sel),
        .load_use  (load_use_b)
    );

    assign load_use = load_use_a || load_use_b;
    assign hold     = (state != HZ_RUN);

    // A pending data-memory access freezes everything, including the FSM.
    assign stall_all   = mem_entry.valid && (mem_entry.mem_read || mem_entry.mem_write) && !mem_ready;
    assign stall_if_id = !stall_all && (load_use || hold);
    assign flush_id_ex = !stall_all && (load_use || hold || ex_branch_taken);
    assign flush_if_id = !stall_all && ex_branch_taken;

    // The ID instruction behind a taken branch is wrong-path and cannot trap.
    assign illegal = (state == HZ_RUN) && id_valid && (id_decode_failed || id_reg_illegal)
                     && !ex_branch_taken;

    assign trap       = (state == HZ_TRAP);
    assign halted     = (state == HZ_HALT);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_entry  <= '0;
            mem_entry <= '0;
        end else if (!stall_all) begin
            mem_entry <= ex_entry;
            if (flush_id_ex || stall_if_id) begin
                ex_entry <= '0;
            end else begin
                ex_entry <= id_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HZ_RUN;
            drain_cnt <= '0;
            cause_q   <= CAUSE_NONE;
        end else if (!stall_all) begin
            unique case (state)
                HZ_RUN: begin
                    if (illegal) begin
                        cause_q   <= trap_cause_type'({id_reg_illegal, id_decode_failed});
                        drain_cnt <= DRAIN_LOAD;
                        state     <= HZ_DRAIN;
                    end
                end
                HZ_DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= HZ_TRAP;
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                HZ_TRAP: begin
                    state <= HZ_HALT;
                end
                HZ_HALT: begin
                    if (resume) begin
                        cause_q <= CAUSE_NONE;
                        state   <= HZ_RUN;
                    end
                end
                default: begin
                    state <= HZ_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, forwarding, memory wait and trap sequencing.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic            clk;
    logic            reset;
    logic            id_valid;
    instruction_type id_instr;
    control_type     id_control;
    logic            id_decode_failed;
    logic            id_reg_illegal;
    logic            ex_branch_taken;
    logic            mem_ready;
    logic            resume;
    logic            stall_if_id;
    logic            stall_all;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic            trap;
    logic [1:0]      trap_cause;
    logic            halted;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.DRAIN_CYCLES(2), .FWD_SEL_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_instr         (id_instr),
        .id_control       (id_control),
        .id_decode_failed (id_decode_failed),
        .id_reg_illegal   (id_reg_illegal),
        .ex_branch_taken  (ex_branch_taken),
        .mem_ready        (mem_ready),
        .resume           (resume),
        .stall_if_id      (stall_if_id),
        .stall_all        (stall_all),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .fwd_a_sel        (fwd_a_sel),
        .fwd_b_sel        (fwd_b_sel),
        .trap             (trap),
        .trap_cause       (trap_cause),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input format_type f,
                         input logic rw, input logic mr, input logic mw);
        id_valid         = v;
        id_instr         = instr;
        id_control       = '{fmt: f, reg_write: rw, mem_read: mr, mem_write: mw};
        id_decode_failed = 1'b0;
        id_reg_illegal   = 1'b0;
        ex_branch_taken  = 1'b0;
        resume           = 1'b0;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'h0, FMT_R, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        drive(1'b0, 32'h0, FMT_R, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL rst_stall_if_id got=%0b want=0", stall_if_id); end
        total++; if (stall_all !== 1'b0) begin bad++; $display("FAIL rst_stall_all got=%0b want=0", stall_all); end
        total++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin bad++; $display("FAIL rst_flush got=%b want=00", {flush_if_id, flush_id_ex}); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'h0) begin bad++; $display("FAIL rst_fwd got=%h want=0", {fwd_a_sel, fwd_b_sel}); end
        total++; if ({trap, trap_cause, halted} !== 4'h0) begin bad++; $display("FAIL rst_trap got=%b want=0000", {trap, trap_cause, halted}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        drive(1'b1, enc(5'd5, 5'd1, 5'd0), FMT_I, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_pre_stall got=%0b want=0", stall_if_id); end
        tick();
        drive(1'b1, enc(5'd6, 5'd5, 5'd2), FMT_R, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (stall_if_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", stall_if_id); end
        total++; if (flush_id_ex !== 1'b1) begin bad++; $display("FAIL lu_flush got=%0b want=1", flush_id_ex); end
        tick();
        @(negedge clk);
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL lu_resolved_stall got=%0b want=0", stall_if_id); end
        total++; if (flush_id_ex !== 1'b0) begin bad++; $display("FAIL lu_resolved_flush got=%0b want=0", flush_id_ex); end
        total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL lu_fwd_a got=%0d want=2", fwd_a_sel); end
        total++; if (fwd_b_sel !== 2'd0) begin bad++; $display("FAIL lu_fwd_b got=%0d want=0", fwd_b_sel); end
        tick();
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, enc(5'd3, 5'd0, 5'd0), FMT_I, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, enc(5'd4, 5'd0, 5'd0), FMT_I, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL b2b_stall1 got=%0b want=0", stall_if_id); end
        tick();
        drive(1'b1, enc(5'd7, 5'd3, 5'd4), FMT_R, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL b2b_fwd_a got=%0d want=2", fwd_a_sel); end
        total++; if (fwd_b_sel !== 2'd1) begin bad++; $display("FAIL b2b_fwd_b got=%0d want=1", fwd_b_sel); end
        total++; if ({stall_if_id, flush_id_ex} !== 2'b00) begin bad++; $display("FAIL b2b_nostall got=%b want=00", {stall_if_id, flush_id_ex}); end
        tick();
        idle(2);
    endtask

    task automatic test_x0_dest();
        drive(1'b1, enc(5'd0, 5'd1, 5'd2), FMT_R, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, enc(5'd5, 5'd0, 5'd0), FMT_R, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'h0) begin bad++; $display("FAIL x0_fwd got=%h want=0", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", stall_if_id); end
        tick();
        drive(1'b1, enc(5'd0, 5'd1, 5'd0), FMT_I, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, enc(5'd6, 5'd0, 5'd0), FMT_R, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL x0_load_stall got=%0b want=0", stall_if_id); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'h0) begin bad++; $display("FAIL x0_load_fwd got=%h want=0", {fwd_a_sel, fwd_b_sel}); end
        tick();
        idle(2);
    endtask

    task automatic test_mem_wait();
        drive(1'b1, enc(5'd8, 5'd1, 5'd0), FMT_I, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (stall_all !== 1'b0) begin bad++; $display("FAIL mw_pre got=%0b want=0", stall_all); end
        tick();
        drive(1'b1, enc(5'd10, 5'd0, 5'd0), FMT_I, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, enc(5'd11, 5'd10, 5'd8), FMT_R, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (stall_all !== 1'b1) begin bad++; $display("FAIL mw_stall_all[%0d] got=%0b want=1", i, stall_all); end
            total++; if ({stall_if_id, flush_id_ex} !== 2'b00) begin bad++; $display("FAIL mw_masked[%0d] got=%b want=00", i, {stall_if_id, flush_id_ex}); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== {2'd1, 2'd2}) begin bad++; $display("FAIL mw_shadow[%0d] got=%h want=6", i, {fwd_a_sel, fwd_b_sel}); end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        total++; if (stall_all !== 1'b0) begin bad++; $display("FAIL mw_release got=%0b want=0", stall_all); end
        total++; if (stall_if_id !== 1'b1) begin bad++; $display("FAIL mw_lu_stall got=%0b want=1", stall_if_id); end
        tick();
        @(negedge clk);
        total++; if ({fwd_a_sel, fwd_b_sel} !== {2'd2, 2'd0}) begin bad++; $display("FAIL mw_advanced got=%h want=8", {fwd_a_sel, fwd_b_sel}); end
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL mw_after_stall got=%0b want=0", stall_if_id); end
        tick();
        idle(2);
    endtask

    task automatic test_illegal_trap();
        drive(1'b1, 32'hFFFF_FFFF, FMT_R, 1'b0, 1'b0, 1'b0);
        id_decode_failed = 1'b1;
        @(negedge clk);
        total++; if ({stall_if_id, trap, halted} !== 3'b000) begin bad++; $display("FAIL ill_run got=%b want=000", {stall_if_id, trap, halted}); end
        tick();
        drive(1'b0, 32'h0, FMT_R, 1'b0, 1'b0, 1'b0);
        resume = 1'b1;
        @(negedge clk);
        total++; if ({stall_if_id, flush_id_ex} !== 2'b11) begin bad++; $display("FAIL ill_drain1 got=%b want=11", {stall_if_id, flush_id_ex}); end
        total++; if (trap !== 1'b0) begin bad++; $display("FAIL ill_drain1_trap got=%0b want=0", trap); end
        total++; if (trap_cause !== 2'd1) begin bad++; $display("FAIL ill_drain1_cause got=%0d want=1", trap_cause); end
        tick();
        resume = 1'b0;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        total++; if ({stall_if_id, flush_if_id, trap} !== 3'b110) begin bad++; $display("FAIL ill_drain2 got=%b want=110", {stall_if_id, flush_if_id, trap}); end
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        total++; if (trap !== 1'b1) begin bad++; $display("FAIL ill_trap got=%0b want=1", trap); end
        total++; if (trap_cause !== 2'd1) begin bad++; $display("FAIL ill_trap_cause got=%0d want=1", trap_cause); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL ill_trap_halted got=%0b want=0", halted); end
        tick();
        @(negedge clk);
        total++; if ({halted, trap, stall_if_id} !== 3'b101) begin bad++; $display("FAIL ill_halt1 got=%b want=101", {halted, trap, stall_if_id}); end
        tick();
        resume = 1'b1;
        @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL ill_halt2 got=%0b want=1", halted); end
        total++; if (trap_cause !== 2'd1) begin bad++; $display("FAIL ill_halt2_cause got=%0d want=1", trap_cause); end
        tick();
        resume = 1'b0;
        @(negedge clk);
        total++; if ({halted, trap, stall_if_id} !== 3'b000) begin bad++; $display("FAIL ill_resumed got=%b want=000", {halted, trap, stall_if_id}); end
        total++; if (trap_cause !== 2'd0) begin bad++; $display("FAIL ill_resumed_cause got=%0d want=0", trap_cause); end
        tick();
        idle(2);
    endtask

    task automatic test_wrong_path();
        drive(1'b1, 32'h0000_0013, FMT_I, 1'b1, 1'b0, 1'b0);
        id_reg_illegal  = 1'b1;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        total++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin bad++; $display("FAIL wp_flush got=%b want=11", {flush_if_id, flush_id_ex}); end
        total++; if (stall_if_id !== 1'b0) begin bad++; $display("FAIL wp_stall got=%0b want=0", stall_if_id); end
        tick();
        drive(1'b0, 32'h0, FMT_R, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({stall_if_id, trap, halted} !== 3'b000) begin bad++; $display("FAIL wp_run[%0d] got=%b want=000", i, {stall_if_id, trap, halted}); end
            tick();
        end
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 32'hFFFF_FFFF, FMT_R, 1'b0, 1'b0, 1'b0);
        id_decode_failed = 1'b1;
        id_reg_illegal   = 1'b1;
        tick();
        drive(1'b0, 32'h0, FMT_R, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (trap_cause !== 2'd3) begin bad++; $display("FAIL rmo_cause got=%0d want=3", trap_cause); end
        total++; if (stall_if_id !== 1'b1) begin bad++; $display("FAIL rmo_drain got=%0b want=1", stall_if_id); end
        reset = 1'b1;
        #1;
        total++; if ({stall_if_id, flush_id_ex, trap_cause, halted, trap} !== 6'b0) begin bad++; $display("FAIL rmo_async got=%b want=000000", {stall_if_id, flush_id_ex, trap_cause, halted, trap}); end
        #1;
        reset = 1'b0;
        tick();
        @(negedge clk);
        total++; if ({stall_if_id, trap_cause} !== 3'b000) begin bad++; $display("FAIL rmo_after got=%b want=000", {stall_if_id, trap_cause}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_x0_dest();
        test_mem_wait();
        test_illegal_trap();
        test_wrong_path();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
